bram_port_arbiter: RTL

Round-robin arbiter that shares the single-port feature/weight BRAM among NREQ requesters: host image/weight loader, layer controller, and BRAM readback checker. Grants are held for bursts of up to MAX_BURST beats. The block muxes the owner's address, write-enable and write data onto the BRAM port, and routes read-return valids back to the requester that issued each read. It sits between the CNN layer sequencer/controller and the BRAM instance.

---
 rtl/bram_port_arbiter_pkg.sv | 16 +
 rtl/bram_port_arbiter_if.sv | 33 +++
 rtl/bram_port_arbiter_rr_pick.sv | 25 ++
 rtl/bram_port_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and types for the feature/weight BRAM port arbiter.
// The requester ids and the default widths match the layer controller's memory port.
package bram_port_arbiter_pkg;
    localparam int REQ_HOST  = 0;
    localparam int REQ_CTRL  = 1;
    localparam int REQ_CHECK = 2;

    localparam int NREQ_DEF = REQ_CHECK + 1;
    localparam int AW_DEF   = 14;
    localparam int DW_DEF   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;
endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side signal bundle for the port arbiter.
// The master modport is the environment (requesters plus BRAM); the slave modport is the arbiter.
interface bram_port_arbiter_if
    import bram_port_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    mask;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_en;
    logic               wea;
    logic [AW-1:0]      memaddr;
    logic [DW-1:0]      mem_din;
    logic [DW-1:0]      mem_dout;

    modport master (
        output req, we, addr, wdata, mask, mem_dout,
        input  gnt, rvalid, rdata, mem_en, wea, memaddr, mem_din
    );

    modport slave (
        input  req, we, addr, wdata, mask, mem_dout,
        output gnt, rvalid, rdata, mem_en, wea, memaddr, mem_din
    );
endinterface

// File: rtl/bram_port_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of vec_i at or after start_i, with wrap.
module bram_port_arbiter_rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] vec_i,
    input  logic [IW-1:0]   start_i,
    output logic            valid_o,
    output logic [NREQ-1:0] onehot_o
);
    int j;

    always_comb begin
        valid_o  = 1'b0;
        onehot_o = '0;
        j        = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(start_i) + i) % NREQ;
            if (!valid_o && vec_i[j]) begin
                valid_o     = 1'b1;
                onehot_o[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port BRAM among NREQ requesters,
// with a read-tag delay line that steers rvalid back to the requester that issued each read.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    bram_port_arbiter_if.slave       bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   din_q;

    logic [NREQ-1:0] ereq, others, pick_vec, pick_oh, rtag_out;
    logic [IW-1:0]   owner_idx, owner_nxt, pick_start;
    logic [CW-1:0]   cnt_inc;
    logic            beat, at_limit, release_now, pick_vld, we_own;
    logic [AW-1:0]   addr_own;
    logic [DW-1:0]   din_own;

    assign ereq        = bus.req & ~bus.mask;
    assign beat        = |(ereq & gnt_q);
    assign others      = ereq & ~gnt_q;
    assign cnt_inc     = cnt_q + 1'b1;
    assign at_limit    = beat && (cnt_inc == CW'(MAX_BURST));
    assign release_now = !beat || (at_limit && |others);
    assign owner_nxt   = (owner_idx == IW'(NREQ - 1)) ? '0 : owner_idx + 1'b1;

    // Idle arbitration starts at rr_ptr; a releasing owner searches from its successor and never re-picks itself.
    assign pick_vec   = (state_q == ST_IDLE) ? ereq : others;
    assign pick_start = (state_q == ST_IDLE) ? rr_ptr_q : owner_nxt;

    bram_port_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .vec_i    (pick_vec),
        .start_i  (pick_start),
        .valid_o  (pick_vld),
        .onehot_o (pick_oh)
    );

    always_comb begin
        owner_idx = '0;
        we_own    = 1'b0;
        addr_own  = '0;
        din_own   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) begin
                owner_idx = IW'(k);
                we_own    = bus.we[k];
                addr_own  = bus.addr[k*AW +: AW];
                din_own   = bus.wdata[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_OWN;
                    gnt_d   = pick_oh;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (release_now) begin
                    rr_ptr_d = owner_nxt;
                    cnt_d    = '0;
                    gnt_d    = pick_oh;
                    state_d  = pick_vld ? ST_OWN : ST_IDLE;
                end else if (at_limit) begin
                    // Nobody else is waiting: restart the burst without giving up the port.
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_comb begin
        bus.gnt     = gnt_q;
        bus.mem_en  = beat;
        bus.wea     = beat & we_own;
        bus.memaddr = beat ? addr_own : addr_q;
        bus.mem_din = beat ? din_own : din_q;
        bus.rvalid  = rtag_out;
        bus.rdata   = (|rtag_out) ? bus.mem_dout : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            din_q  <= '0;
        end else if (beat) begin
            addr_q <= addr_own;
            din_q  <= din_own;
        end
    end

    // Each stage carries the one-hot id of the reader; it runs independently of later grant changes.
    for (genvar s = 0; s < RD_LAT; s++) begin : g_tag
        logic [NREQ-1:0] tag_q;
        if (s == 0) begin : g_head
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) tag_q <= '0;
                else      tag_q <= (beat && !we_own) ? gnt_q : '0;
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) tag_q <= '0;
                else      tag_q <= g_tag[s-1].tag_q;
            end
        end
    end

    assign rtag_out = g_tag[RD_LAT-1].tag_q;
endmodule
